// File: rtl/ets_mem_responder_if.sv
// ets_mem_responder_if: PicoRV32 native memory bus bundle.
// master = requester (core), slave = responder (memory).
interface ets_mem_responder_if;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_instr, mem_addr,
    output mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_instr, mem_addr,
    input  mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/ets_mem_responder.sv
// ets_mem_responder: BRAM responder with fixed wait states.
// Optional jitter: define ETS_WAIT_JITTER_EN.
module ets_mem_responder #(
  parameter int unsigned MEM_WORDS   = 1024,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned JITTER_MAX  = 3
) (
  input  logic               clk,
  input  logic               rst,
  ets_mem_responder_if.slave bus,
  output logic               err_oob,
  input  logic               stat_clear,
  output logic [31:0]        stat_fetches,
  output logic [31:0]        stat_reads,
  output logic [31:0]        stat_writes
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [29:0] BASE_W = ADDR_BASE[31:2];

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [4:0]  r_cnt;
  logic [4:0]  w_cnt_nxt;
  logic [4:0]  w_load;
  logic [2:0]  w_jit;
  logic        w_accept;
  logic        w_fire;

  logic [29:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_instr;

  logic [29:0] w_addr;
  logic [31:0] w_wdata;
  logic [3:0]  w_wstrb;
  logic        w_instr;
  logic [30:0] w_diff;
  logic        w_inrange;
  logic [AW-1:0] w_idx;

  logic [31:0] r_mem [MEM_WORDS];
  logic        r_ready;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_fetches;
  logic [31:0] r_reads;
  logic [31:0] r_writes;

`ifdef ETS_WAIT_JITTER_EN
  logic [7:0] r_lfsr;

  // LFSR (taps 8,6,5,4) steps once per accepted request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= 8'hA5;
    end else if (w_accept) begin
      r_lfsr <= {r_lfsr[6:0],
                 r_lfsr[7] ^ r_lfsr[5] ^
                 r_lfsr[4] ^ r_lfsr[3]};
    end
  end

  assign w_jit = 3'(32'(r_lfsr[2:0]) % (JITTER_MAX + 1));
`else
  assign w_jit = 3'd0;
`endif

  assign w_load = 5'(WAIT_STATES) + {2'b00, w_jit};

  // Zero-wait responses complete on the accept edge,
  // so the live bus is used while idle.
  assign w_addr  = (r_state == S_IDLE) ?
                   bus.mem_addr[31:2] : r_addr;
  assign w_wdata = (r_state == S_IDLE) ?
                   bus.mem_wdata : r_wdata;
  assign w_wstrb = (r_state == S_IDLE) ?
                   bus.mem_wstrb : r_wstrb;
  assign w_instr = (r_state == S_IDLE) ?
                   bus.mem_instr : r_instr;

  // Borrow bit flags addresses below the base
  assign w_diff    = {1'b0, w_addr} - {1'b0, BASE_W};
  assign w_inrange = !w_diff[30] &&
                     (w_diff[29:AW] == '0);
  assign w_idx     = w_diff[AW-1:0];

  // Next-state, wait counter and accept decode
  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    w_accept  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.mem_valid) begin
          w_accept  = 1'b1;
          w_cnt_nxt = w_load;
          w_next    = (w_load == 5'd0) ?
                      S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!bus.mem_valid) begin
          w_next = S_IDLE;
        end else if (r_cnt == 5'd1) begin
          w_next = S_RESP;
        end else begin
          w_cnt_nxt = r_cnt - 5'd1;
        end
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_fire = (w_next == S_RESP);

  // State register and request latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_instr <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_addr  <= bus.mem_addr[31:2];
        r_wdata <= bus.mem_wdata;
        r_wstrb <= bus.mem_wstrb;
        r_instr <= bus.mem_instr;
      end
    end
  end

  // Byte-lane writes, committed on the edge into RESP
  always_ff @(posedge clk) begin
    if (w_fire && w_inrange) begin
      for (int b = 0; b < 4; b++) begin
        if (w_wstrb[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
        end
      end
    end
  end

  // Response pulse, read data and statistics
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ready   <= 1'b0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_fetches <= '0;
      r_reads   <= '0;
      r_writes  <= '0;
    end else begin
      r_ready <= w_fire;
      if (w_fire && (w_wstrb == 4'd0)) begin
        r_rdata <= w_inrange ? r_mem[w_idx] : 32'd0;
      end
      if (stat_clear) begin
        r_err     <= 1'b0;
        r_fetches <= '0;
        r_reads   <= '0;
        r_writes  <= '0;
      end else if (w_fire) begin
        if (!w_inrange) r_err <= 1'b1;
        if (w_wstrb != 4'd0) begin
          if (r_writes != '1) r_writes <= r_writes + 1;
        end else if (w_instr) begin
          if (r_fetches != '1) r_fetches <= r_fetches + 1;
        end else begin
          if (r_reads != '1) r_reads <= r_reads + 1;
        end
      end
    end
  end

  assign bus.mem_ready = r_ready;
  assign bus.mem_rdata = r_rdata;
  assign err_oob       = r_err;
  assign stat_fetches  = r_fetches;
  assign stat_reads    = r_reads;
  assign stat_writes   = r_writes;

endmodule

// File: tb/tb_ets_mem_responder.sv
// tb_ets_mem_responder: random requests vs a behavioural
// memory/statistics model.
module tb_ets_mem_responder;
  localparam int WS = 2;
  localparam int JM = 3;
  localparam int MW = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stat_clear = 1'b0;
  logic        err_oob;
  logic [31:0] st_f, st_r, st_w;

  ets_mem_responder_if bus();

  ets_mem_responder #(
    .MEM_WORDS  (MW),
    .ADDR_BASE  (32'h0000_0000),
    .WAIT_STATES(WS),
    .JITTER_MAX (JM)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .err_oob     (err_oob),
    .stat_clear  (stat_clear),
    .stat_fetches(st_f),
    .stat_reads  (st_r),
    .stat_writes (st_w)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  int last_rdy = -100;

  logic [31:0] m_mem [MW];
  logic [31:0] m_f, m_r, m_w, m_rdata;
  logic        m_err;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_stats();
    chk("err_oob", 32'(err_oob), 32'(m_err));
    chk("fetches", st_f, m_f);
    chk("reads", st_r, m_r);
    chk("writes", st_w, m_w);
  endtask

  task automatic model_zero();
    m_f = 0; m_r = 0; m_w = 0; m_err = 1'b0;
  endtask

  task automatic req(input logic instr,
                     input logic [31:0] addr,
                     input logic [31:0] wdata,
                     input logic [3:0] wstrb,
                     input logic clr,
                     input logic b2b);
    int n;
    int idx;
    logic inr;
    @(posedge clk);
    @(negedge clk);
    bus.mem_valid = 1'b1;
    bus.mem_instr = instr;
    bus.mem_addr  = addr;
    bus.mem_wdata = wdata;
    bus.mem_wstrb = wstrb;
    stat_clear    = clr;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
      if (n == 1) begin
        bus.mem_addr  = $urandom;
        bus.mem_wdata = $urandom;
        bus.mem_wstrb = 4'($urandom);
        bus.mem_instr = 1'($urandom);
      end
    end while (!bus.mem_ready && n < 40);
    if (!bus.mem_ready) begin
      chk("timeout", 32'd0, 32'd1);
      bus.mem_valid = 1'b0;
      stat_clear = 1'b0;
      return;
    end
    bus.mem_valid = 1'b0;
    stat_clear = 1'b0;
`ifdef ETS_WAIT_JITTER_EN
    chk("lat_rng", 32'(n >= WS + 1 && n <= WS + 1 + JM), 32'd1);
`else
    chk("latency", n, WS + 1);
    if (b2b) chk("b2b", cyc - last_rdy, WS + 2);
`endif
    last_rdy = cyc;
    inr = (addr >> 2) < MW;
    idx = int'(addr[11:2]);
    if (!inr) m_err = 1'b1;
    if (wstrb != 4'd0) begin
      m_w++;
      if (inr) begin
        for (int b = 0; b < 4; b++)
          if (wstrb[b]) m_mem[idx][8*b +: 8] = wdata[8*b +: 8];
      end
    end else begin
      if (instr) m_f++;
      else m_r++;
      m_rdata = inr ? m_mem[idx] : 32'd0;
    end
    if (clr) model_zero();
    chk("rdata", bus.mem_rdata, m_rdata);
    chk_stats();
  endtask

  initial begin
    int a;
    logic [3:0] s;
    bus.mem_valid = 1'b0;
    bus.mem_instr = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wstrb = '0;
    model_zero();
    m_rdata = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.mem_ready), 32'd0);
    chk("rst_rdata", bus.mem_rdata, 32'd0);
    chk_stats();
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 32; i++) begin
      req(1'b0, 32'(i * 4), $urandom, 4'hF, 1'b0, i > 0);
    end
    req(1'b0, 32'h10, 32'h1234_5678, 4'hF, 1'b0, 1'b1);
    req(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 1'b1);
    chk("tp_rd", bus.mem_rdata, 32'h1234_5678);

    req(1'b0, 32'h20, 32'hAABB_CCDD, 4'hF, 1'b0, 1'b0);
    req(1'b0, 32'h20, 32'h1122_3344, 4'b0101, 1'b0, 1'b1);
    req(1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 1'b1);
    chk("strobe", bus.mem_rdata, 32'hAA22_CC44);

    req(1'b0, 32'h1000, 32'h0, 4'h0, 1'b0, 1'b0);
    chk("oob_flag", 32'(err_oob), 32'd1);
    @(negedge clk);
    stat_clear = 1'b1;
    @(negedge clk);
    stat_clear = 1'b0;
    model_zero();
    chk_stats();

    req(1'b0, 32'h2000, 32'h5, 4'hF, 1'b1, 1'b0);

    @(posedge clk);
    @(negedge clk);
    bus.mem_valid = 1'b1;
    bus.mem_instr = 1'b0;
    bus.mem_addr  = 32'h14;
    bus.mem_wdata = 32'hDEAD_0001;
    bus.mem_wstrb = 4'hF;
    @(posedge clk);
    @(negedge clk);
    bus.mem_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("abort_rdy", 32'(bus.mem_ready), 32'd0);
    end
    chk_stats();
    req(1'b0, 32'h14, 32'h0, 4'h0, 1'b0, 1'b0);

    @(posedge clk);
    @(negedge clk);
    bus.mem_valid = 1'b1;
    bus.mem_instr = 1'b0;
    bus.mem_addr  = 32'h0;
    bus.mem_wdata = 32'hDEAD_BEEF;
    bus.mem_wstrb = 4'hF;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    bus.mem_valid = 1'b0;
    #1;
    chk("rst_mid_rdy", 32'(bus.mem_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst_hold_rdy", 32'(bus.mem_ready), 32'd0);
    end
    model_zero();
    m_rdata = '0;
    chk("rst_mid_rdata", bus.mem_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    req(1'b1, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 99) < 15)
        a = 32'h1000 + int'($urandom_range(0, 32'hFFFF));
      else
        a = int'($urandom_range(0, 127));
      s = ($urandom_range(0, 99) < 35) ?
          4'($urandom_range(1, 15)) : 4'h0;
      req(1'($urandom), 32'(a), $urandom, s, 1'b0, i > 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ets_mem_responder.md
Name: ets_mem_responder

Overview:
- Responder end of the PicoRV32 native memory bus (mem_valid/mem_ready handshake). It sits on the external memory port of the ETS RISC-V top level.
- Provides word-addressed BRAM with a programmable, deterministic wait-state latency, byte-strobe writes, out-of-range error flagging and access statistics.
- Deterministic latency is required so that ETS cycle signatures are reproducible; optional jitter injection supports detection testing.

Parameters:
- MEM_WORDS, 1024, memory depth in 32-bit words (power of two, >= 16).
- ADDR_BASE, 32'h0000_0000, byte address of word 0 (aligned to MEM_WORDS*4).
- WAIT_STATES, 1, extra cycles between accept and mem_ready (0..15).
- JITTER_MAX, 3, maximum extra random wait cycles when jitter is compiled in (0..7).

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- mem_valid  in  1  request valid; held by requester until mem_ready.
- mem_instr  in  1  request is an instruction fetch (statistics only).
- mem_addr  in  32  byte address; bits [1:0] ignored.
- mem_wdata  in  32  write data.
- mem_wstrb  in  4  byte write enables; 0 means read.
- mem_ready  out  1  one-cycle completion pulse.
- mem_rdata  out  32  read data, valid when mem_ready=1.
- err_oob  out  1  sticky out-of-range access flag.
- stat_clear  in  1  synchronous clear of err_oob and all counters.
- stat_fetches  out  32  completed instruction fetches.
- stat_reads  out  32  completed data reads.
- stat_writes  out  32  completed writes.

Behaviour:
- Reset: mem_ready=0, mem_rdata=0, err_oob=0, all counters=0, FSM=IDLE, LFSR=seed 8'hA5. Memory array is not cleared.
- Reset asserted mid-transaction drops it: no write is committed and no ready is issued.
- FSM states: IDLE, WAIT, RESP.
- IDLE: when mem_valid=1, latch addr/wdata/wstrb/instr (accept cycle t) and load the wait counter with WAIT_STATES (+ jitter, if compiled in).
  - Counter zero -> RESP.
  - Otherwise -> WAIT.
- WAIT: decrement the counter each cycle; counter reaches 1 -> RESP next cycle.
  - If mem_valid drops during WAIT: abort to IDLE, no write, no ready, no counter update.
- RESP: mem_ready=1 for exactly this cycle, then IDLE.
  - Completion cycle = t+1+WAIT_STATES (+ jitter).
  - mem_ready is registered; never combinational from mem_valid.
  - The requester must deassert mem_valid the cycle after ready. A new accept is possible from the cycle after RESP, giving back-to-back spacing of WAIT_STATES+2 cycles.
- Request inputs changing after accept are ignored; the latched copies are used.
- Address decode: offset = latched_addr - ADDR_BASE; word index = offset[..:2]. In range iff addr >= ADDR_BASE and index < MEM_WORDS.
- Read (wstrb=0): mem_rdata = mem[index] in the RESP cycle.
  - mem_rdata holds its value after RESP until the next response.
- Write (wstrb!=0): in the RESP cycle each byte lane with strobe=1 is updated; mem_rdata is unchanged.
- Out-of-range access:
  - Still completes with the normal latency.
  - Read returns 32'h0000_0000; write is dropped.
  - err_oob is set in the RESP cycle and stays set until stat_clear or rst.
- Counters: each increments by 1 in the RESP cycle of its access class and saturates at 32'hFFFF_FFFF.
  - Fetch vs read is decided by the latched mem_instr; write is decided by wstrb!=0.
  - Out-of-range accesses are counted.
- stat_clear takes priority over a same-cycle increment or err_oob set: the result is 0.

Optional Feature:
- Macro ETS_WAIT_JITTER_EN.
- Defined: an 8-bit Fibonacci LFSR (taps 8,6,5,4) advances at every accept. Extra wait = LFSR[2:0] mod (JITTER_MAX+1), added to WAIT_STATES at accept.
- Undefined: no LFSR; latency is exactly WAIT_STATES+1 cycles from accept to ready.

Test Plan:
- WAIT_STATES=2: write 0x1234_5678 to 0x0000_0010 with wstrb=4'hF -> ready exactly at t+3; then a read of 0x10 returns 0x1234_5678; stat_writes=1, stat_reads=1.
- Byte strobes: word 0x20 = 0xAABB_CCDD, write 0x1122_3344 with wstrb=4'b0101 -> read returns 0xAA22_CC44.
- Out of range (MEM_WORDS=1024): read 0x0000_1000 -> ready at normal latency, rdata=0, err_oob=1. Then stat_clear -> err_oob=0, counters=0.
- Abort: WAIT_STATES=4, write accepted, mem_valid dropped at t+2 -> no ready pulse; memory unchanged; stat_writes=0; next request accepted normally.
- Reset mid-WAIT: assert rst at t+1 -> mem_ready=0 immediately and stays 0; after release, a fetch of 0x0 returns the preloaded word with stat_fetches=1.
- WAIT_STATES=0: back-to-back fetches -> ready every 2 cycles. With ETS_WAIT_JITTER_EN defined, latency across 100 reads is always within 1..1+JITTER_MAX.
